// File: rtl/regbank_spi_port.sv
// SPI-slave debug port onto the SH-1 register bank: 40-bit frames (8-bit command, 32-bit data)
// become single-cycle register reads/writes. Optional status byte in the command phase: REGBANK_SPI_STATUS_EN.
module regbank_spi_port #(
    parameter int REG_WIDTH = 32,
    parameter int REG_COUNT = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk_i,
    input  logic                         cs_n_i,
    input  logic                         mosi_i,
    output logic                         miso_o,
    output logic                         miso_oe_o,
    input  logic                         core_halted_i,
    output logic [$clog2(REG_COUNT)-1:0] rb_raddr_o,
    input  logic [REG_WIDTH-1:0]         rb_rdata_i,
    output logic                         rb_we_o,
    output logic [$clog2(REG_COUNT)-1:0] rb_waddr_o,
    output logic [REG_WIDTH-1:0]         rb_wdata_o,
    output logic                         busy_o,
    output logic                         err_o
);
    localparam int AW         = $clog2(REG_COUNT);
    localparam int FRAME_BITS = 8 + REG_WIDTH;
    localparam int CW         = $clog2(FRAME_BITS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic       sclk_prev_q, cs_prev_q;

    // cs_n synchronizer resets high so miso_oe stays low out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= 2'b00;
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], sclk_i};
            cs_sync_q   <= {cs_sync_q[0], cs_n_i};
            mosi_sync_q <= {mosi_sync_q[0], mosi_i};
            sclk_prev_q <= sclk_sync_q[1];
            cs_prev_q   <= cs_sync_q[1];
        end
    end

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
    assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q[1] & sclk_prev_q;
    assign cs_rise   = cs_sync_q[1] & ~cs_prev_q;
    assign cs_fall   = ~cs_sync_q[1] & cs_prev_q;
    assign mosi_s    = mosi_sync_q[1];

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        bitcnt_q, bitcnt_d;
    logic [REG_WIDTH-2:0] rx_q, rx_d;
    logic [7:0]           cmd_q, cmd_d;
    logic [REG_WIDTH-1:0] tx_q, tx_d;
    logic                 tx_live_q, tx_live_d;
    logic                 cap_q, cap_d;
    logic [AW-1:0]        raddr_q, raddr_d;
    logic                 we_q, we_d;
    logic [AW-1:0]        waddr_q, waddr_d;
    logic [REG_WIDTH-1:0] wdata_q, wdata_d;
    logic                 err_q, err_d;
`ifdef REGBANK_SPI_STATUS_EN
    logic [7:0]           status_q, status_d;
`endif

    logic [7:0] cmd_next;
    logic       cmd_bad;
    assign cmd_next = {rx_q[6:0], mosi_s};
    assign cmd_bad  = |cmd_q[6:4];

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        rx_d      = rx_q;
        cmd_d     = cmd_q;
        tx_d      = tx_q;
        tx_live_d = tx_live_q;
        cap_d     = 1'b0;
        raddr_d   = raddr_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
`ifdef REGBANK_SPI_STATUS_EN
        status_d  = status_q;
`endif
        // rb_rdata settles one cycle after rb_raddr moves; invalid commands read back zero
        if (cap_q)
            tx_d = cmd_bad ? '0 : rb_rdata_i;

        if (cs_rise) begin
            state_d   = S_IDLE;
            tx_live_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cs_fall) begin
                        state_d   = S_CMD;
                        bitcnt_d  = '0;
                        tx_live_d = 1'b0;
`ifdef REGBANK_SPI_STATUS_EN
                        status_d  = {4'hA, err_q, core_halted_i, 2'b00};
`endif
                    end
                end
                S_CMD: begin
`ifdef REGBANK_SPI_STATUS_EN
                    if (sclk_fall)
                        status_d = {status_q[6:0], 1'b0};
`endif
                    if (sclk_rise) begin
                        rx_d     = {rx_q[REG_WIDTH-3:0], mosi_s};
                        bitcnt_d = bitcnt_q + CW'(1);
                        if (bitcnt_q == CW'(7)) begin
                            cmd_d   = cmd_next;
                            raddr_d = cmd_next[AW-1:0];
                            cap_d   = 1'b1;
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    // first falling edge of the data phase exposes bit 31, later ones shift
                    if (sclk_fall) begin
                        if (tx_live_q)
                            tx_d = {tx_q[REG_WIDTH-2:0], 1'b0};
                        else
                            tx_live_d = 1'b1;
                    end
                    if (sclk_rise) begin
                        rx_d     = {rx_q[REG_WIDTH-3:0], mosi_s};
                        bitcnt_d = bitcnt_q + CW'(1);
                        if (bitcnt_q == CW'(FRAME_BITS - 1)) begin
                            state_d = S_DONE;
                            if (cmd_bad) begin
                                err_d = 1'b1;
                            end else if (cmd_q[7]) begin
                                if (core_halted_i) begin
                                    we_d    = 1'b1;
                                    waddr_d = cmd_q[AW-1:0];
                                    wdata_d = {rx_q, mosi_s};
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bitcnt_q  <= '0;
            rx_q      <= '0;
            cmd_q     <= '0;
            tx_q      <= '0;
            tx_live_q <= 1'b0;
            cap_q     <= 1'b0;
            raddr_q   <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
`ifdef REGBANK_SPI_STATUS_EN
            status_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            rx_q      <= rx_d;
            cmd_q     <= cmd_d;
            tx_q      <= tx_d;
            tx_live_q <= tx_live_d;
            cap_q     <= cap_d;
            raddr_q   <= raddr_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
`ifdef REGBANK_SPI_STATUS_EN
            status_q  <= status_d;
`endif
        end
    end

    always_comb begin
        miso_o = 1'b0;
        if (state_q == S_DATA || state_q == S_DONE)
            miso_o = tx_live_q & tx_q[REG_WIDTH-1];
`ifdef REGBANK_SPI_STATUS_EN
        else if (state_q == S_CMD)
            miso_o = status_q[7];
`endif
    end

    assign miso_oe_o  = ~cs_sync_q[1];
    assign rb_raddr_o = raddr_q;
    assign rb_we_o    = we_q;
    assign rb_waddr_o = waddr_q;
    assign rb_wdata_o = wdata_q;
    assign busy_o     = (state_q != S_IDLE);
    assign err_o      = err_q;

endmodule

// File: tb/tb_regbank_spi_port.sv
// Directed + randomized bench for regbank_spi_port; register bank and expected contents modelled here.
module tb_regbank_spi_port;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0, core_halted = 1'b0;
    logic        miso, miso_oe, rb_we, busy, err;
    logic [3:0]  rb_raddr, rb_waddr;
    logic [31:0] rb_rdata, rb_wdata;

    logic [31:0] bank [16];
    logic [31:0] exp_regs [16];
    logic        tb_we = 1'b0;
    logic [3:0]  tb_waddr = '0;
    logic [31:0] tb_wdata = '0;
    int          we_cycles = 0;
    int          checks = 0, failures = 0;
    bit          err_m;

    always #5 clk = ~clk;

    regbank_spi_port #(.REG_WIDTH(32), .REG_COUNT(16)) dut (
        .clk(clk), .rst_n(rst_n), .sclk_i(sclk), .cs_n_i(cs_n), .mosi_i(mosi),
        .miso_o(miso), .miso_oe_o(miso_oe), .core_halted_i(core_halted),
        .rb_raddr_o(rb_raddr), .rb_rdata_i(rb_rdata), .rb_we_o(rb_we),
        .rb_waddr_o(rb_waddr), .rb_wdata_o(rb_wdata), .busy_o(busy), .err_o(err)
    );

    assign rb_rdata = bank[rb_raddr];

    always @(posedge clk) begin
        if (rb_we) begin
            bank[rb_waddr] <= rb_wdata;
            we_cycles      <= we_cycles + 1;
        end else if (tb_we) begin
            bank[tb_waddr] <= tb_wdata;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_status(input bit e, input bit h);
`ifdef REGBANK_SPI_STATUS_EN
        return {4'hA, e, h, 2'b00};
`else
        return 8'h00;
`endif
    endfunction

    task automatic half();
        repeat (6) @(negedge clk);
    endtask

    task automatic poke(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        tb_waddr = a; tb_wdata = d; tb_we = 1'b1;
        @(negedge clk);
        tb_we = 1'b0;
        exp_regs[a] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        err_m = 1'b0;
    endtask

    // Shifts nbits of {cmd,data}; miso captured just before each rising edge
    task automatic xfer(input logic [7:0] cmd, input logic [31:0] data, input int nbits,
                        output logic [7:0] st, output logic [31:0] rd);
        logic [39:0] f;
        f = {cmd, data}; st = '0; rd = '0;
        for (int b = 0; b < nbits; b++) begin
            mosi = f[39-b];
            half();
            if (b < 8) st = {st[6:0], miso};
            else       rd = {rd[30:0], miso};
            sclk = 1'b1;
            half();
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] cmd, input logic [31:0] data,
                         output logic [7:0] st, output logic [31:0] rd);
        cs_n = 1'b0;
        half();
        xfer(cmd, data, 40, st, rd);
        half();
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [7:0]  st;
        logic [31:0] rd, d;
        logic [3:0]  a;
        logic [7:0]  c;
        bit          w, h, wr_ok;
        int          we0;

        for (int i = 0; i < 16; i++) begin
            bank[i] = $urandom;
            exp_regs[i] = bank[i];
        end
        do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_miso", 64'(miso), 64'(0));
        check("reset_miso_oe", 64'(miso_oe), 64'(0));
        check("reset_raddr", 64'(rb_raddr), 64'(0));
        check("reset_we", 64'(rb_we), 64'(0));
        check("reset_waddr", 64'(rb_waddr), 64'(0));
        check("reset_wdata", 64'(rb_wdata), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_err", 64'(err), 64'(0));
        do_reset();

        // halted write of R5
        core_halted = 1'b1;
        we0 = we_cycles;
        frame(8'h85, 32'hDEADBEEF, st, rd);
        check("wr_status", 64'(st), 64'(exp_status(1'b0, 1'b1)));
        check("wr_prevalue", 64'(rd), 64'(exp_regs[5]));
        check("wr_pulses", 64'(we_cycles - we0), 64'(1));
        check("wr_waddr", 64'(rb_waddr), 64'(5));
        check("wr_wdata", 64'(rb_wdata), 64'(32'hDEADBEEF));
        check("wr_err", 64'(err), 64'(0));
        exp_regs[5] = 32'hDEADBEEF;

        // read R3
        poke(4'd3, 32'h12345678);
        we0 = we_cycles;
        frame(8'h03, 32'hFFFF_FFFF, st, rd);
        check("rd_data", 64'(rd), 64'(32'h12345678));
        check("rd_no_we", 64'(we_cycles - we0), 64'(0));

        // write while running: dropped, sticky error
        core_halted = 1'b0;
        we0 = we_cycles;
        frame(8'h8A, 32'h1, st, rd);
        check("run_no_we", 64'(we_cycles - we0), 64'(0));
        check("run_err", 64'(err), 64'(1));
        check("run_waddr_hold", 64'(rb_waddr), 64'(5));
        err_m = 1'b1;
        frame(8'h0A, 32'h0, st, rd);
        check("run_rd_status", 64'(st), 64'(exp_status(1'b1, 1'b0)));
        check("run_rd_data", 64'(rd), 64'(exp_regs[10]));
        check("run_err_sticky", 64'(err), 64'(1));

        // abort after 20 bits
        do_reset();
        core_halted = 1'b1;
        we0 = we_cycles;
        cs_n = 1'b0;
        half();
        xfer(8'h87, 32'hCAFEF00D, 20, st, rd);
        cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        repeat (8) @(negedge clk);
        check("abort_no_we", 64'(we_cycles - we0), 64'(0));
        check("abort_err", 64'(err), 64'(0));
        frame(8'h87, 32'h0BADCAFE, st, rd);
        check("abort_next_prev", 64'(rd), 64'(exp_regs[7]));
        check("abort_next_we", 64'(we_cycles - we0), 64'(1));
        exp_regs[7] = 32'h0BADCAFE;
        frame(8'h07, 32'h0, st, rd);
        check("abort_readback", 64'(rd), 64'(32'h0BADCAFE));

        // randomized valid frames against the model
        for (int n = 0; n < 12; n++) begin
            a = 4'($urandom_range(0, 15));
            w = 1'($urandom_range(0, 1));
            h = 1'($urandom_range(0, 1));
            d = $urandom;
            c = {w, 3'b000, a};
            core_halted = h;
            wr_ok = w && h;
            we0 = we_cycles;
            frame(c, d, st, rd);
            check("rnd_status", 64'(st), 64'(exp_status(err_m, h)));
            check("rnd_rd", 64'(rd), 64'(exp_regs[a]));
            check("rnd_we", 64'(we_cycles - we0), 64'(wr_ok ? 1 : 0));
            if (wr_ok) begin
                check("rnd_waddr", 64'(rb_waddr), 64'(a));
                check("rnd_wdata", 64'(rb_wdata), 64'(d));
                exp_regs[a] = d;
            end
            if (w && !h) err_m = 1'b1;
            check("rnd_err", 64'(err), 64'(err_m));
        end

        // invalid command, then reset mid-frame
        core_halted = 1'b1;
        we0 = we_cycles;
        frame(8'h93, 32'h5555AAAA, st, rd);
        check("inv_miso", 64'(rd), 64'(0));
        check("inv_no_we", 64'(we_cycles - we0), 64'(0));
        check("inv_err", 64'(err), 64'(1));
        cs_n = 1'b0;
        half();
        xfer(8'h85, 32'h13579BDF, 15, st, rd);
        check("mid_busy_pre", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check("mid_miso", 64'(miso), 64'(0));
        check("mid_miso_oe", 64'(miso_oe), 64'(0));
        check("mid_raddr", 64'(rb_raddr), 64'(0));
        check("mid_we", 64'(rb_we), 64'(0));
        check("mid_waddr", 64'(rb_waddr), 64'(0));
        check("mid_wdata", 64'(rb_wdata), 64'(0));
        check("mid_busy", 64'(busy), 64'(0));
        check("mid_err", 64'(err), 64'(0));
        do_reset();
        check("mid_no_we", 64'(we_cycles - we0), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
